// File: rtl/cmos_pkg.sv
// Shared defaults and state encoding for the CMOS crop/decimate path.
package cmos_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 13;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/edge_det.sv
// Frame-sync edge detector: vsync rising edge and href falling edge, one-cycle pulses.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic vsync_rise,
  output logic href_fall
);

  logic vsync_q;
  logic href_q;

  // vsync history resets high so a vsync already high at reset release is not a start
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  assign vsync_rise = vsync & ~vsync_q;
  assign href_fall  = ~href & href_q;

endmodule

// File: rtl/cmos_crop_decim.sv
// Crops a window out of the captured CMOS stream, optionally decimates 2:1 on both
// axes, and forwards surviving pixels to the SDRAM write port with frame bookkeeping.
module cmos_crop_decim
  import cmos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 cam_pclk,
  input  logic                 rst,
  input  logic                 frame_vsync,
  input  logic                 frame_href,
  input  logic                 frame_valid,
  input  logic [DATA_W-1:0]    frame_data,
  input  logic [CNT_W-1:0]     cfg_x0,
  input  logic [CNT_W-1:0]     cfg_y0,
  input  logic [CNT_W-1:0]     cfg_w,
  input  logic [CNT_W-1:0]     cfg_h,
  input  logic                 cfg_decim,
  output logic                 wr_en,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic [2*CNT_W-1:0]   out_pix_cnt
);

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [2*CNT_W-1:0] PIX_MAX = '1;

  state_t state, state_nxt;

  logic vsync_rise;
  logic href_fall;

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic [2*CNT_W-1:0] pix_cnt;

  logic [CNT_W-1:0] x0_s;
  logic [CNT_W-1:0] y0_s;
  logic [CNT_W-1:0] w_s;
  logic [CNT_W-1:0] h_s;
  logic             decim_s;

  logic start_pend;

  logic             open_frame;
  logic             close_frame;
  logic             pix_pass;
  logic [CNT_W:0]   x_end;
  logic [CNT_W:0]   y_end;
  logic             in_x;
  logic             in_y;
  logic             on_grid;

  edge_det u_edge (
    .clk        (cam_pclk),
    .rst        (rst),
    .vsync      (frame_vsync),
    .href       (frame_href),
    .vsync_rise (vsync_rise),
    .href_fall  (href_fall)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge cam_pclk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    open_frame  = 1'b0;
    close_frame = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (vsync_rise) begin
          state_nxt  = ACTIVE;
          open_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (vsync_rise) begin
          close_frame = 1'b1;
          open_frame  = 1'b1;
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // ---------------------------------------------------------------- window test
  // One extra bit on the window end so x0+w never wraps back into range.
  always_comb begin
    x_end   = {1'b0, x0_s} + {1'b0, w_s};
    y_end   = {1'b0, y0_s} + {1'b0, h_s};
    in_x    = (h_cnt >= x0_s) && ({1'b0, h_cnt} < x_end);
    in_y    = (v_cnt >= y0_s) && ({1'b0, v_cnt} < y_end);
    // parity of (cnt - origin) is just the xor of the low bits
    on_grid = ~(h_cnt[0] ^ x0_s[0]) & ~(v_cnt[0] ^ y0_s[0]);
    pix_pass = (state == ACTIVE) && frame_valid && !vsync_rise
            && in_x && in_y && (!decim_s || on_grid);
  end

  // ---------------------------------------------------------------- counters / shadow cfg
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pix_cnt <= '0;
      x0_s    <= '0;
      y0_s    <= '0;
      w_s     <= '0;
      h_s     <= '0;
      decim_s <= 1'b0;
    end else if (open_frame) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pix_cnt <= '0;
      x0_s    <= cfg_x0;
      y0_s    <= cfg_y0;
      w_s     <= cfg_w;
      h_s     <= cfg_h;
      decim_s <= cfg_decim;
    end else if (state == ACTIVE) begin
      if (href_fall) begin
        h_cnt <= '0;
        if (v_cnt != CNT_MAX) v_cnt <= v_cnt + 1'b1;
      end else if (frame_valid && h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (pix_pass && pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  // frame_done lands the cycle after the closing vsync edge, frame_start one cycle later.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      start_pend  <= 1'b0;
      out_pix_cnt <= '0;
    end else begin
      wr_en       <= pix_pass;
      if (pix_pass) wr_data <= frame_data;
      frame_done  <= close_frame;
      start_pend  <= close_frame;
      frame_start <= (open_frame && !close_frame) || start_pend;
      if (close_frame) out_pix_cnt <= pix_cnt;
    end
  end

endmodule

// File: tb/tb_cmos_crop_decim.sv
// Scoreboard bench: stimulus pushes expected pixels/frame counts, a negedge monitor checks them.
module tb_cmos_crop_decim;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 13;

  logic                cam_pclk = 1'b0;
  logic                rst;
  logic                frame_vsync;
  logic                frame_href;
  logic                frame_valid;
  logic [DATA_W-1:0]   frame_data;
  logic [CNT_W-1:0]    cfg_x0, cfg_y0, cfg_w, cfg_h;
  logic                cfg_decim;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                frame_start;
  logic                frame_done;
  logic [2*CNT_W-1:0]  out_pix_cnt;

  cmos_crop_decim #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .cam_pclk    (cam_pclk),
    .rst         (rst),
    .frame_vsync (frame_vsync),
    .frame_href  (frame_href),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .cfg_x0      (cfg_x0),
    .cfg_y0      (cfg_y0),
    .cfg_w       (cfg_w),
    .cfg_h       (cfg_h),
    .cfg_decim   (cfg_decim),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .out_pix_cnt (out_pix_cnt)
  );

  always #5 cam_pclk = ~cam_pclk;

  int cyc = 0;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                c;
  } exp_t;

  exp_t pix_q[$];
  int   done_q[$];

  int n_vec = 0;
  int n_err = 0;
  int start_exp = 0;
  int start_seen = 0;
  int done_cyc = -10;
  bit start_after_done = 0;

  // bench's own view of the frame in flight
  int fx0, fy0, fw, fh;
  bit fdec;
  bit m_active = 0;
  int row = 0;
  int fid = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  function automatic bit pass(input int c, input int r);
    if (c < fx0 || c >= fx0 + fw || r < fy0 || r >= fy0 + fh) return 1'b0;
    if (fdec && (((c - fx0) % 2) != 0 || ((r - fy0) % 2) != 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input bit d);
    cfg_x0    = CNT_W'(x0);
    cfg_y0    = CNT_W'(y0);
    cfg_w     = CNT_W'(w);
    cfg_h     = CNT_W'(h);
    cfg_decim = d;
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_en",       wr_en,       0);
    check("rst_wr_data",     wr_data,     0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_done",  frame_done,  0);
    check("rst_out_pix_cnt", out_pix_cnt, 0);
  endtask

  // A pixel rides on the vsync rising edge; it must be dropped.
  task automatic vsync_pulse(input int exp_done);
    frame_vsync = 1'b1;
    frame_valid = 1'b1;
    frame_data  = 16'hDEAD;
    fx0 = int'(cfg_x0); fy0 = int'(cfg_y0);
    fw  = int'(cfg_w);  fh  = int'(cfg_h);
    fdec = cfg_decim;
    if (m_active) begin
      done_q.push_back(exp_done);
      start_after_done = 1'b1;
    end
    start_exp++;
    m_active = 1'b1;
    row = 0;
    fid++;
    tick();
    frame_valid = 1'b0;
    tick(); tick();
    frame_vsync = 1'b0;
    tick(); tick();
  endtask

  // 16x8 frame, pixels on alternate cycles; optional reset at pixel index rst_at,
  // optional cfg_w change to 4 at the start of row wchg_row.
  task automatic send_frame(input int rst_at, input int wchg_row);
    for (int r = 0; r < 8; r++) begin
      if (r == wchg_row) cfg_w = CNT_W'(4);
      frame_href = 1'b1;
      tick();
      for (int c = 0; c < 16; c++) begin
        frame_data  = {4'(fid), 6'(r), 6'(c)};
        frame_valid = 1'b1;
        if (r * 16 + c == rst_at) begin
          rst = 1'b1;
          m_active = 1'b0;
          tick();
          check_reset_outputs();
          rst = 1'b0;
        end else begin
          if (m_active && pass(c, r)) pix_q.push_back('{frame_data, cyc + 1});
          tick();
        end
        frame_valid = 1'b0;
        tick();
      end
      frame_href = 1'b0;
      tick(); tick();
      row++;
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge cam_pclk) begin
    if (!rst) begin
      if (wr_en) begin
        if (pix_q.size() == 0) check("unexpected_wr_en", 1, 0);
        else begin
          exp_t e;
          e = pix_q.pop_front();
          check("wr_data", wr_data, e.d);
          check("wr_latency_cycle", cyc, e.c);
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("out_pix_cnt", out_pix_cnt, done_q.pop_front());
        done_cyc = cyc;
      end
      if (frame_start) begin
        start_seen++;
        if (start_after_done) begin
          check("start_after_done_cycle", cyc, done_cyc + 1);
          start_after_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    frame_vsync = 1'b0;
    frame_href  = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    set_cfg(0, 0, 16, 8, 1'b0);
    tick(); tick(); tick();
    check_reset_outputs();
    rst = 1'b0;
    tick(); tick();

    // full frame, 128 pixels in order
    vsync_pulse(0);
    send_frame(-1, -1);
    // cropped + decimated: cols 4,6,8,10 of rows 2,4
    set_cfg(4, 2, 8, 4, 1'b1);
    vsync_pulse(128);
    send_frame(-1, -1);
    // 8 wide, width changes to 4 mid-frame
    set_cfg(0, 0, 8, 8, 1'b0);
    vsync_pulse(8);
    send_frame(-1, 3);
    // now 4 wide
    vsync_pulse(64);
    send_frame(-1, -1);
    // reset at pixel 50
    set_cfg(0, 0, 16, 8, 1'b0);
    vsync_pulse(32);
    send_frame(50, -1);
    // recovery frame, complete
    vsync_pulse(0);
    send_frame(-1, -1);
    // window runs past line end: cols 12..15
    set_cfg(12, 0, 10, 8, 1'b0);
    vsync_pulse(128);
    send_frame(-1, -1);
    // zero height
    set_cfg(0, 0, 16, 0, 1'b0);
    vsync_pulse(32);
    send_frame(-1, -1);
    vsync_pulse(0);
    repeat (6) tick();

    check("pix_q_drained", pix_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("frame_start_count", start_seen, start_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
